dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Two-port arbiter and sequencer for the data memory (dm). Port 0 = CPU load/store unit, port 1 = DMA/debug loader.
//  Issues only full-word dm ops. Stores narrower than a word become read-modify-write with byte-lane placement from addr[1:0].
//  Loads are extracted and extended from the addressed lane.
//  Misaligned accesses are refused with an error response.
// PARAMETERS
//  ADDR_W  9  byte-address width of requester ports; dm word address = addr[ADDR_W-1:2]
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         asynchronous, active-high reset
//  req0/req1  in   1         access request; hold it and all fields stable until ack
//  we0/we1    in   1         1 = store, 0 = load
//  addr0/1    in   ADDR_W    byte address
//  type0/1    in   3         `dm_* size/sign code from ctrl_encode_def.v
//  wdata0/1   in   32        store data, LSB-aligned (byte in [7:0], half in [15:0])
//  ack0/ack1  out  1         one-cycle completion pulse
//  err0/err1  out  1         valid with ack; 1 = misaligned, no memory effect
//  rdata0/1   out  32        load result, valid with ack; 0 for stores and errors
//  busy       out  1         FSM not in IDLE
//  dm_wr      out  1         to dm.DMWr
//  dm_addr    out  ADDR_W-2  to dm.addr
//  dm_type    out  3         tied to `dm_word
//  dm_din     out  32        to dm.din
//  dm_dout    in   32        from dm.dout (combinational read of dm_addr)
// BEHAVIOUR
//  Reset: state=IDLE. ack*, err*, rdata*, dm_wr and busy = 0. dm_addr=0, dm_din=0, last_grant=1.
//  Reset mid-operation aborts the operation. dm_wr drops immediately. No partial write is issued afterward.
//  FSM states: IDLE, RD, WR, RESP.
//  IDLE: with any req, arbitrate and latch the winner's we/addr/type/wdata into the op register. A losing req waits.
//  Alignment check:
//   - halfword requires addr[0]=0
//   - word requires addr[1:0]=0
//   - on failure, go to RESP with err=1
//  Transitions:
//   - load -> RD
//   - word store -> WR
//   - byte/half store -> RD
//  RD: dm_addr=op word address. Capture dm_dout into the read buffer.
//   - load -> RESP
//   - sub-word store -> WR
//  WR: dm_wr=1 for exactly one cycle, then RESP.
//   - word store: dm_din=wdata
//   - sub-word store: dm_din=read buffer with lane(s) at addr[1:0] replaced by wdata[7:0] or wdata[15:0]
//  RESP: ack and err of the granted port asserted for one cycle, then IDLE. rdata is valid in this cycle.
//   - requester must drop req in the cycle after ack, else a new request is taken
//  Load extraction: lane = word >> (8*addr[1:0]).
//   - `dm_byte / `dm_halfword: sign-extend
//   - `dm_byte_unsigned / `dm_halfword_unsigned: zero-extend
//   - `dm_word: unchanged
//  Stores use only size: unsigned codes behave as the signed ones. Unknown type codes = word.
//  Latency from grant: load 2 cycles, word store 2, sub-word store 3, error 1. Minimum 1 idle cycle between operations.
//  The idle (un-granted) port's ack/err/rdata stay 0.
//  busy=1 in RD, WR, RESP.
// CONFIGURATION
//  DMCTRL_RR_EN defined:
//   - round-robin arbitration
//   - on simultaneous req0 and req1, grant the port != last_grant
//   - last_grant updates at every grant
//  DMCTRL_RR_EN undefined:
//   - fixed priority, port 0 always wins ties
//   - last_grant is unused
// TESTING
//  Word store: port0 we=1 addr=0x10 type=`dm_word wdata=0xDEADBEEF -> dm_wr 1 cycle, dm_addr=4, din=0xDEADBEEF; ack0 2 cycles after grant.
//  Byte RMW: mem[4]=0x11223344; port0 store byte addr=0x12 wdata=0xAB -> dm_din=0x11AB3344; ack0 3 cycles after grant.
//  Loads from mem[4]=0x11AB3344:
//   - lb addr 0x12 -> rdata=0xFFFFFFAB
//   - lbu addr 0x12 -> 0x000000AB
//   - lh addr 0x12 -> 0x000011AB
//  Misalign: lw addr 0x11 -> ack0 & err0 1 cycle after grant, rdata0=0, dm_wr never asserted, memory unchanged.
//  Contention: req0 and req1 both held.
//   - RR_EN: grants alternate 0,1,0,1
//   - without RR_EN: port 1 waits until req0 drops
//  Reset: rst asserted during WR of a byte store -> dm_wr=0 immediately, IDLE, all outputs 0, no ack issued.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Bundle of requester-side and data-memory-side signals for dm_access_ctrl.
// The slave modport is the controller; master is whatever drives requests and the memory read data.
interface dm_access_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [2:0]        type0;
    logic [2:0]        type1;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [31:0]       rdata0;
    logic [31:0]       rdata1;
    logic              busy;
    logic              dm_wr;
    logic [ADDR_W-3:0] dm_addr;
    logic [2:0]        dm_type;
    logic [31:0]       dm_din;
    logic [31:0]       dm_dout;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, type0, type1, wdata0, wdata1, dm_dout,
        input  ack0, ack1, err0, err1, rdata0, rdata1, busy, dm_wr, dm_addr, dm_type, dm_din
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, type0, type1, wdata0, wdata1, dm_dout,
        output ack0, ack1, err0, err1, rdata0, rdata1, busy, dm_wr, dm_addr, dm_type, dm_din
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Two-port data-memory arbiter/sequencer: full-word dm ops, sub-word stores via read-modify-write.
// Define DMCTRL_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dm_access_ctrl #(
    parameter int ADDR_W = 9
) (
    input logic              clk,
    input logic              rst,
    dm_access_ctrl_if.slave  bus
);
    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    function automatic logic is_byte(input logic [2:0] t);
        return (t == DM_BYTE) || (t == DM_BYTE_UNSIGNED);
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return (t == DM_HALFWORD) || (t == DM_HALFWORD_UNSIGNED);
    endfunction

    state_t            state;
    state_t            state_nx;
    logic              op_we;
    logic              op_port;
    logic              op_err;
    logic [ADDR_W-1:0] op_addr;
    logic [2:0]        op_type;
    logic [31:0]       op_wdata;
    logic [31:0]       rbuf;

    logic              any_req;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_type;
    logic [31:0]       sel_wdata;
    logic              sel_misaligned;
    logic              sel_sub_word;

    assign any_req = bus.req0 | bus.req1;

`ifdef DMCTRL_RR_EN
    logic last_grant;

    always_comb begin
        grant_port = bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_port = ~last_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_port;
        end
    end
`else
    always_comb begin
        grant_port = ~bus.req0;
    end
`endif

    // Unknown size codes fall through to the word rules (full alignment, no lane work).
    always_comb begin
        sel_we    = grant_port ? bus.we1    : bus.we0;
        sel_addr  = grant_port ? bus.addr1  : bus.addr0;
        sel_type  = grant_port ? bus.type1  : bus.type0;
        sel_wdata = grant_port ? bus.wdata1 : bus.wdata0;
        sel_sub_word = is_byte(sel_type) || is_half(sel_type);
        if (is_half(sel_type)) begin
            sel_misaligned = sel_addr[0];
        end else if (is_byte(sel_type)) begin
            sel_misaligned = 1'b0;
        end else begin
            sel_misaligned = |sel_addr[1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (sel_misaligned) begin
                        state_nx = RESP;
                    end else if (sel_we && !sel_sub_word) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:      state_nx = op_we ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_we    <= 1'b0;
            op_port  <= 1'b0;
            op_err   <= 1'b0;
            op_addr  <= '0;
            op_type  <= DM_WORD;
            op_wdata <= '0;
            rbuf     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                op_we    <= sel_we;
                op_port  <= grant_port;
                op_err   <= sel_misaligned;
                op_addr  <= sel_addr;
                op_type  <= sel_type;
                op_wdata <= sel_wdata;
            end
            if (state == RD) begin
                rbuf <= bus.dm_dout;
            end
        end
    end

    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // Store merge: only the addressed lane(s) of the fetched word are replaced.
    always_comb begin
        merged = rbuf;
        if (is_byte(op_type)) begin
            case (op_addr[1:0])
                2'd0:    merged[7:0]   = op_wdata[7:0];
                2'd1:    merged[15:8]  = op_wdata[7:0];
                2'd2:    merged[23:16] = op_wdata[7:0];
                default: merged[31:24] = op_wdata[7:0];
            endcase
        end else if (is_half(op_type)) begin
            if (op_addr[1]) begin
                merged[31:16] = op_wdata[15:0];
            end else begin
                merged[15:0]  = op_wdata[15:0];
            end
        end else begin
            merged = op_wdata;
        end
    end

    always_comb begin
        shifted = rbuf >> {op_addr[1:0], 3'b000};
        case (op_type)
            DM_BYTE:              load_val = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTE_UNSIGNED:     load_val = {24'd0, shifted[7:0]};
            DM_HALFWORD:          load_val = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFWORD_UNSIGNED: load_val = {16'd0, shifted[15:0]};
            default:              load_val = shifted;
        endcase
    end

    logic resp;
    logic resp_data;

    assign resp      = (state == RESP);
    assign resp_data = resp && !op_err && !op_we;

    assign bus.ack0    = resp && !op_port;
    assign bus.ack1    = resp &&  op_port;
    assign bus.err0    = resp && !op_port && op_err;
    assign bus.err1    = resp &&  op_port && op_err;
    assign bus.rdata0  = (resp_data && !op_port) ? load_val : 32'd0;
    assign bus.rdata1  = (resp_data &&  op_port) ? load_val : 32'd0;
    assign bus.busy    = (state != IDLE);
    assign bus.dm_wr   = (state == WR);
    assign bus.dm_addr = op_addr[ADDR_W-1:2];
    assign bus.dm_type = DM_WORD;
    assign bus.dm_din  = (state == WR) ? merged : 32'd0;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: directed requests push expected responses/writes,
// an independent negedge monitor pops and compares them against what the DUT presents.
module tb_dm_access_ctrl;
    localparam int ADDR_W = 9;
    localparam logic [2:0] DM_WORD = 3'b000;
    localparam logic [2:0] DM_HALF = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [ADDR_W-3:0] addr;
        logic [31:0]       din;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    resp_t resp_q[$];
    wr_t   wr_q[$];
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];

    dm_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dm_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on the clock edge.
    assign bus.dm_dout = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.dm_wr) begin
            mem[bus.dm_addr] <= bus.dm_din;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: any ack or dm write must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ack0 || bus.ack1) begin
                checkOutput("single_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    checkOutput("ack_port", 32'(bus.ack1), 32'(e.port));
                    checkOutput("err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(e.err));
                    checkOutput("rdata", bus.ack1 ? bus.rdata1 : bus.rdata0, e.rdata);
                    checkOutput("idle_port_err", 32'(bus.ack1 ? bus.err0 : bus.err1), 32'd0);
                    checkOutput("idle_port_rdata", bus.ack1 ? bus.rdata0 : bus.rdata1, 32'd0);
                end
            end
            if (bus.dm_wr) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_dm_wr", 32'(bus.dm_wr), 32'd0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    checkOutput("dm_addr", 32'(bus.dm_addr), 32'(w.addr));
                    checkOutput("dm_din", bus.dm_din, w.din);
                    checkOutput("dm_type", 32'(bus.dm_type), 32'(DM_WORD));
                end
            end
        end
    end

    task automatic drivePort(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [2:0] typ, input logic [31:0] wdata);
        if (port) begin
            bus.we1 = we; bus.addr1 = addr; bus.type1 = typ; bus.wdata1 = wdata;
        end else begin
            bus.we0 = we; bus.addr0 = addr; bus.type0 = typ; bus.wdata0 = wdata;
        end
    endtask

    // Issue one request from an idle controller and measure cycles from request sampling to ack.
    task automatic applyStimulus(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [2:0] typ, input logic [31:0] wdata,
                                 input logic exp_err, input logic [31:0] exp_rdata,
                                 input int exp_lat, input logic exp_write, input logic [31:0] exp_din);
        int cnt;
        logic got;
        resp_t e;
        wr_t w;
        e.port = port; e.err = exp_err; e.rdata = exp_rdata;
        resp_q.push_back(e);
        if (exp_write) begin
            w.addr = addr[ADDR_W-1:2]; w.din = exp_din;
            wr_q.push_back(w);
        end
        @(negedge clk);
        drivePort(port, we, addr, typ, wdata);
        if (port) bus.req1 = 1'b1; else bus.req0 = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
            if (port ? bus.ack1 : bus.ack0) got = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checkOutput($sformatf("latency@%03h", addr), 32'(cnt), 32'(exp_lat));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << (ADDR_W-2)); i++) mem[i] <= 32'd0;
        mem[4] <= 32'h11223344;
        mem[8] <= 32'hCAFEF00D;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int cyc;
        logic seen;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drivePort(1'b0, 1'b0, '0, DM_WORD, 32'd0);
        drivePort(1'b1, 1'b0, '0, DM_WORD, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_dm_wr", 32'(bus.dm_wr), 32'd0);
        checkOutput("rst_acks", 32'({bus.ack1, bus.ack0, bus.err1, bus.err0}), 32'd0);
        checkOutput("rst_rdata0", bus.rdata0, 32'd0);
        checkOutput("rst_rdata1", bus.rdata1, 32'd0);
        checkOutput("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        checkOutput("rst_dm_din", bus.dm_din, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Contention: both ports hold word loads; order depends on arbitration mode.
        begin
            resp_t e;
`ifdef DMCTRL_RR_EN
            e.err = 1'b0;
            e.port = 1'b0; e.rdata = 32'h11223344; resp_q.push_back(e);
            e.port = 1'b1; e.rdata = 32'hCAFEF00D; resp_q.push_back(e);
            e.port = 1'b0; e.rdata = 32'h11223344; resp_q.push_back(e);
            e.port = 1'b1; e.rdata = 32'hCAFEF00D; resp_q.push_back(e);
`else
            e.err = 1'b0;
            e.port = 1'b0; e.rdata = 32'h11223344; resp_q.push_back(e);
            e.port = 1'b0; e.rdata = 32'h11223344; resp_q.push_back(e);
            e.port = 1'b0; e.rdata = 32'h11223344; resp_q.push_back(e);
            e.port = 1'b1; e.rdata = 32'hCAFEF00D; resp_q.push_back(e);
`endif
        end
        @(negedge clk);
        drivePort(1'b0, 1'b0, 9'h010, DM_WORD, 32'd0);
        drivePort(1'b1, 1'b0, 9'h020, DM_WORD, 32'd0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        n = 0;
        cyc = 0;
`ifndef DMCTRL_RR_EN
        while (n < 3 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (bus.ack0 || bus.ack1) n++;
        end
        bus.req0 = 1'b0;
`endif
        while (n < 4 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            if (bus.ack0 || bus.ack1) n++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checkOutput("contention_acks", 32'(n), 32'd4);
        repeat (2) @(posedge clk);

        //            port we  addr    type     wdata         err   rdata         lat wr    din
        applyStimulus(1'b0, 1, 9'h010, DM_WORD,  32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1'b1, 32'hDEADBEEF);
        applyStimulus(1'b1, 0, 9'h010, DM_WORD,  32'h0,        1'b0, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        applyStimulus(1'b1, 1, 9'h010, DM_WORD,  32'h11223344, 1'b0, 32'h00000000, 2, 1'b1, 32'h11223344);
        applyStimulus(1'b0, 1, 9'h012, DM_BYTE,  32'h123456AB, 1'b0, 32'h00000000, 3, 1'b1, 32'h11AB3344);
        applyStimulus(1'b0, 0, 9'h012, DM_BYTE,  32'h0,        1'b0, 32'hFFFFFFAB, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h012, DM_BYTEU, 32'h0,        1'b0, 32'h000000AB, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h012, DM_HALF,  32'h0,        1'b0, 32'h000011AB, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h011, DM_WORD,  32'h0,        1'b1, 32'h00000000, 1, 1'b0, 32'h0);
        applyStimulus(1'b1, 0, 9'h013, DM_HALF,  32'h0,        1'b1, 32'h00000000, 1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1, 9'h011, DM_HALF,  32'hFFFF,     1'b1, 32'h00000000, 1, 1'b0, 32'h0);
        checkOutput("mem_after_misalign", mem[4], 32'h11AB3344);
        applyStimulus(1'b1, 1, 9'h012, DM_HALFU, 32'h00008001, 1'b0, 32'h00000000, 3, 1'b1, 32'h80013344);
        applyStimulus(1'b0, 0, 9'h012, DM_HALF,  32'h0,        1'b0, 32'hFFFF8001, 2, 1'b0, 32'h0);
        applyStimulus(1'b1, 0, 9'h012, DM_HALFU, 32'h0,        1'b0, 32'h00008001, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 1, 9'h013, DM_BYTEU, 32'h0000005A, 1'b0, 32'h00000000, 3, 1'b1, 32'h5A013344);
        applyStimulus(1'b1, 1, 9'h010, DM_BYTE,  32'h000000C3, 1'b0, 32'h00000000, 3, 1'b1, 32'h5A0133C3);
        applyStimulus(1'b0, 0, 9'h010, DM_BYTE,  32'h0,        1'b0, 32'hFFFFFFC3, 2, 1'b0, 32'h0);
        applyStimulus(1'b1, 0, 9'h011, DM_BYTEU, 32'h0,        1'b0, 32'h00000033, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h010, DM_HALFU, 32'h0,        1'b0, 32'h000033C3, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h012, DM_HALF,  32'h0,        1'b0, 32'h00005A01, 2, 1'b0, 32'h0);
        applyStimulus(1'b1, 0, 9'h012, 3'b111,   32'h0,        1'b1, 32'h00000000, 1, 1'b0, 32'h0);
        applyStimulus(1'b1, 0, 9'h010, 3'b111,   32'h0,        1'b0, 32'h5A0133C3, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 1, 9'h020, 3'b101,   32'h0BADC0DE, 1'b0, 32'h00000000, 2, 1'b1, 32'h0BADC0DE);

        // Reset during the write cycle of a byte store must abort it with no ack and no write.
        @(negedge clk);
        drivePort(1'b0, 1'b1, 9'h010, DM_BYTE, 32'h00000055);
        bus.req0 = 1'b1;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 10) begin
            @(posedge clk); #1; cyc++;
            if (bus.dm_wr) seen = 1'b1;
        end
        rst = 1'b1;
        bus.req0 = 1'b0;
        #1;
        checkOutput("rst_mid_wr_seen", 32'(seen), 32'd1);
        checkOutput("rst_mid_dm_wr", 32'(bus.dm_wr), 32'd0);
        checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_mid_acks", 32'({bus.ack1, bus.ack0, bus.err1, bus.err0}), 32'd0);
        checkOutput("rst_mid_dm_din", bus.dm_din, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        checkOutput("mem_after_rst", mem[4], 32'h5A0133C3);
        applyStimulus(1'b1, 0, 9'h010, DM_WORD,  32'h0,        1'b0, 32'h5A0133C3, 2, 1'b0, 32'h0);
        applyStimulus(1'b0, 0, 9'h020, DM_WORD,  32'h0,        1'b0, 32'h0BADC0DE, 2, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        checkOutput("write_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
